// File: rtl/instr_encoder.sv
// instr_encoder
//   Assembles RV32I instruction words (R, I-ALU, I-load, S, B) from field-level
//   inputs and writes them to instruction memory at consecutive word addresses.
//   The write happens one cycle after the instruction is accepted.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_n_i      synchronous active-low reset
//   start_i      restart load: write pointer to BASE_ADDR, count and full cleared
//   in_valid_i   instruction fields valid
//   in_ready_o   encoder accepts this cycle
//   fmt_i        0=R 1=I-ALU 2=I-load 3=S 4=B, 5..7 illegal
//   rd_i/rs1_i/rs2_i, func3_i, sub_i, imm_i   instruction fields
//   mem_we_o     one-cycle write strobe per word
//   mem_addr_o   word address of the current write
//   mem_wdata_o  encoded instruction
//   count_o      words written since reset/start
//   full_o       2^ADDR_W words written; acceptance stops until start
//   err_o        sticky: an illegal fmt was accepted (cleared only by reset)
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        func3_i,
  input  logic              sub_i,
  input  logic [12:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WP_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_IA = 3'd1;
  localparam logic [2:0] FMT_IL = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_IA = 7'b0010011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wp_q,    wp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q,  full_d;
  logic              err_q,   err_d;

  logic        accept;
  logic        legal;
  logic [6:0]  f7;
  logic [31:0] enc;

  // Branch offsets are always even, so imm[0] carries no information.
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];

  // start blocks acceptance so the pointer reset never races a new word.
  assign in_ready_o = rst_n_i & ~full_q & ~start_i;
  assign accept     = in_valid_i & in_ready_o;
  assign legal      = (fmt_i <= FMT_B);
  assign f7         = sub_i ? 7'b0100000 : 7'b0000000;

  always_comb begin
    enc = 32'h0;
    case (fmt_i)
      FMT_R:  enc = {f7, rs2_i, rs1_i, func3_i, rd_i, OP_R};
      FMT_IA: begin
        // Shift-immediates: upper immediate bits select logical vs arithmetic.
        if (func3_i == 3'b001 || func3_i == 3'b101)
          enc = {f7, imm_i[4:0], rs1_i, func3_i, rd_i, OP_IA};
        else
          enc = {imm_i[11:0], rs1_i, func3_i, rd_i, OP_IA};
      end
      FMT_IL: enc = {imm_i[11:0], rs1_i, func3_i, rd_i, OP_IL};
      FMT_S:  enc = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], OP_S};
      FMT_B:  enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                     imm_i[4:1], imm_i[11], OP_B};
      default: enc = 32'h0;
    endcase
  end

  always_comb begin
    we_d    = accept & legal;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wp_d    = wp_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;

    if (accept && legal) begin
      addr_d  = wp_q;
      wdata_d = enc;
    end

    if (start_i) begin
      wp_d    = BASE;
      count_d = '0;
      full_d  = 1'b0;
    end else if (accept && legal) begin
      wp_d    = wp_q + WP_ONE;
      count_d = count_q + CNT_ONE;
      full_d  = (count_q == CNT_LAST);
    end

    if (accept && !legal)
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'h0;
      wp_q    <= BASE;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with ADDR_W=2, BASE_ADDR=0.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    fmt_i;
  logic [4:0]    rd_i, rs1_i, rs2_i;
  logic [2:0]    func3_i;
  logic          sub_i;
  logic [12:0]   imm_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fmt_i       (fmt_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .func3_i     (func3_i),
    .sub_i       (sub_i),
    .imm_i       (imm_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction, let it be accepted, return at the next falling edge.
  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [2:0] f3, input logic sb,
                      input logic [12:0] im);
    fmt_i = f; rd_i = rd; rs1_i = r1; rs2_i = r2; func3_i = f3; sub_i = sb; imm_i = im;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic expect_wr(input string tag, input int addr, input logic [31:0] data);
    check({tag, " we"},    32'(mem_we_o),   32'd1);
    check({tag, " addr"},  32'(mem_addr_o), 32'(addr));
    check({tag, " wdata"}, mem_wdata_o,     data);
  endtask

  task automatic pulse_start();
    in_valid_i = 1'b0;
    start_i    = 1'b1;
    #1 check("ready low during start", 32'(in_ready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    check("start count", 32'(count_o), 32'd0);
    check("start full",  32'(full_o),  32'd0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    fmt_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; func3_i = '0; sub_i = 1'b0; imm_i = '0;
    tick();
    tick();
    check("rst we",    32'(mem_we_o),    32'd0);
    check("rst addr",  32'(mem_addr_o),  32'd0);
    check("rst wdata", mem_wdata_o,      32'd0);
    check("rst count", 32'(count_o),     32'd0);
    check("rst full",  32'(full_o),      32'd0);
    check("rst err",   32'(err_o),       32'd0);
    check("rst ready", 32'(in_ready_o),  32'd0);
    rst_n_i = 1'b1;
    #1 check("ready after rst", 32'(in_ready_o), 32'd1);

    // R pair
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
    expect_wr("add", 0, 32'h002081B3);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0);
    expect_wr("sub", 1, 32'h402081B3);
    in_valid_i = 1'b0;
    check("R count", 32'(count_o), 32'd2);
    tick();
    check("idle we",        32'(mem_we_o),   32'd0);
    check("idle addr hold", 32'(mem_addr_o), 32'd1);
    check("idle data hold", mem_wdata_o,     32'h402081B3);
    pulse_start();

    // I forms back-to-back
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
    expect_wr("addi", 0, 32'h00500093);
    send(3'd1, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 13'd3);
    expect_wr("srai", 1, 32'h40335293);
    in_valid_i = 1'b0;
    check("I count", 32'(count_o), 32'd2);
    pulse_start();

    // S / B
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 13'd8);
    expect_wr("sw", 0, 32'h0020A423);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FFC);
    expect_wr("beq", 1, 32'hFE208EE3);
    send(3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 1'b0, 13'h1FFC);
    expect_wr("lw", 2, 32'hFFC12203);
    in_valid_i = 1'b0;
    pulse_start();

    // Illegal format
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd1);
    in_valid_i = 1'b0;
    check("illegal we",    32'(mem_we_o), 32'd0);
    check("illegal err",   32'(err_o),    32'd1);
    check("illegal count", 32'(count_o),  32'd0);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
    expect_wr("after illegal", 0, 32'h00500093);
    in_valid_i = 1'b0;
    pulse_start();
    check("err sticky over start", 32'(err_o), 32'd1);

    // Fill with in_valid held high
    for (int i = 0; i < 4; i++) begin
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'(i));
      expect_wr($sformatf("fill%0d", i), i, 32'h00000093 | (32'(i) << 20));
    end
    check("fill full",  32'(full_o),     32'd1);
    check("fill count", 32'(count_o),    32'd4);
    check("fill ready", 32'(in_ready_o), 32'd0);
    tick();
    check("full no we",    32'(mem_we_o), 32'd0);
    check("full count",    32'(count_o),  32'd4);
    check("full addr hold", 32'(mem_addr_o), 32'd3);
    pulse_start();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
    expect_wr("restart", 0, 32'h002081B3);
    in_valid_i = 1'b0;
    pulse_start();

    // Reset mid-stream
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0);
    expect_wr("pre-reset", 1, 32'h402081B3);
    rst_n_i = 1'b0;
    #1 check("ready in rst", 32'(in_ready_o), 32'd0);
    tick();
    check("mid rst we",    32'(mem_we_o),   32'd0);
    check("mid rst addr",  32'(mem_addr_o), 32'd0);
    check("mid rst wdata", mem_wdata_o,     32'd0);
    check("mid rst count", 32'(count_o),    32'd0);
    check("mid rst err",   32'(err_o),      32'd0);
    check("mid rst full",  32'(full_o),     32'd0);
    rst_n_i = 1'b1;
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
    expect_wr("post-reset", 0, 32'h00500093);
    in_valid_i = 1'b0;
    check("post-reset count", 32'(count_o), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Field-level RV32I instruction encoder and sequential program loader: the write-side counterpart of the control unit's instruction decoder. It accepts one instruction per valid/ready handshake as format plus register, funct and immediate fields. It assembles the 32-bit word for the formats the control unit decodes (R, I-ALU, I-load, S, B). It writes the words into instruction memory at consecutive word addresses, one cycle after acceptance. The test harness uses it to load programs into instruction memory.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or `start`
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  restart load: address to BASE_ADDR, count and full cleared
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts this cycle; = rst_n & !full & !start
- fmt  in  3  0=R, 1=I-ALU, 2=I-load, 3=S, 4=B, 5..7 illegal
- rd, rs1, rs2  in  5 each  register fields
- func3  in  3  funct3
- sub  in  1  R: funct7=0100000 when 1, else 0; I-ALU shifts: imm[11:5]=0100000 when 1
- imm  in  13  signed immediate; R ignores; I/S use imm[11:0]; B uses imm[12:1], imm[0] ignored
- mem_we  out  1  write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address of current write
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  2^ADDR_W words written; no further acceptance
- err  out  1  sticky: illegal fmt accepted

## Operation
- Accept = in_valid & in_ready. Fields are encoded combinationally and registered into mem_wdata.
- Encodings, opcode in [6:0]:
  - R: {f7, rs2, rs1, func3, rd, 0110011}
  - I-ALU: {imm[11:0], rs1, func3, rd, 0010011}; for func3 001/101, [31:25] = sub ? 0100000 : 0000000, [24:20] = imm[4:0]
  - I-load: {imm[11:0], rs1, func3, rd, 0000011}
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], 0100011}
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 1100011}
- Internal write pointer wp (ADDR_W bits):
  - legal accept: next cycle mem_we=1, mem_addr=wp; then wp+1 mod 2^ADDR_W and count+1.
  - illegal accept: no write, wp and count unchanged, err set. err is cleared only by reset, not by start.
- full asserts in the cycle count reaches 2^ADDR_W. wp has wrapped to BASE_ADDR, but nothing is written until start.
- start: wp=BASE_ADDR, count=0, full=0 next cycle. in_ready is low during start, so no accept is lost. A write already registered from the previous cycle still completes.

## Timing
- Reset (rst_n low at edge): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, wp=BASE_ADDR. in_ready=0 while rst_n low.
- Reset overrides everything. A write pending from the previous cycle is cancelled: mem_we=0 in the cycle after the reset edge.
- Latency: accept at edge N → mem_we/mem_addr/mem_wdata valid for cycle N..N+1, exactly one cycle.
- Throughput: one word per cycle with in_valid held high; addresses strictly consecutive.
- mem_we is low in any cycle not preceded by a legal accept. mem_addr/mem_wdata hold their last values when mem_we=0.
- Last slot: accept with count=2^ADDR_W−1 → write issued; full=1 and in_ready=0 from the next cycle.

## Test plan
- R pair: rd=3, rs1=1, rs2=2, func3=0, sub=0 then sub=1 → 0x002081B3 at addr 0, then 0x402081B3 at addr 1; count=2.
- I forms: addi x1,x0,5 (fmt1, imm=5) → 0x00500093; srai x5,x6,3 (fmt1, func3=5, sub=1, imm=3) → 0x40335293; both written back-to-back, one cycle apart.
- S/B: sw x2,8(x1) (fmt3, func3=2, imm=8) → 0x0020A423; beq x1,x2,−4 (fmt4, imm=13'h1FFC) → 0xFE208EE3.
- Illegal: fmt=7 accepted → no mem_we, err=1. The next legal word is written to the same address the illegal one would have used. err stays 1 across start.
- Fill/restart, ADDR_W=2: 4 legal accepts → addrs 0..3, full=1, count=4, in_ready=0 with in_valid held. Pulse start → count=0, full=0, next write at addr 0.
- Reset mid-stream: rst_n low the cycle after an accept → mem_we=0 next cycle; all outputs at reset values; first post-reset write at BASE_ADDR.
